fp_regfile_xfer: RTL and testbench

- Floating-point register file (coprocessor-1 side) for the Mini-MIPS core.
- Forms the FP end of the shared general/FP transfer bus `fp_gen_transfer`:
  - mtc1: captures a word the general register file drives while `gen_to_fp` is high.
  - mfc1: drives an FP register onto the bus while `fp_to_gen` is high.
- Also holds the FP condition-code flags and a busy scoreboard for multi-cycle FPU ops, which produces a `stall` to the issue stage.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_scoreboard.sv | 54 +++++
 rtl/fp_regfile_xfer.sv | 120 ++++++++++++
 tb/tb_fp_regfile_xfer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the coprocessor-1 (FP) register file slice.
// Holds the default sizes and the transfer-direction encoding used by the
// general/FP transfer bus logic.
package fp_pkg;

    localparam int WIDTH = 32;            // register and bus width
    localparam int NREG  = 32;            // number of FP registers
    localparam int AW    = $clog2(NREG);  // register address width
    localparam int NCC   = 8;             // number of condition-code bits

    // Direction of the general/FP transfer, encoded as {gen_to_fp, fp_to_gen}.
    typedef enum logic [1:0] {
        XFER_NONE     = 2'b00,
        XFER_TO_GEN   = 2'b01,  // mfc1: FP side drives the bus
        XFER_TO_FP    = 2'b10,  // mtc1: FP side captures the bus
        XFER_CONFLICT = 2'b11   // both requested: nothing happens, error flagged
    } xfer_dir_e;

    function automatic xfer_dir_e xfer_dir(input logic gen_to_fp, input logic fp_to_gen);
        return xfer_dir_e'({gen_to_fp, fp_to_gen});
    endfunction

endpackage

// File: rtl/fp_scoreboard.sv
// Busy scoreboard for multi-cycle FPU operations.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   issue_valid/add   multi-cycle op issued; marks its destination busy
//   we/w_add          FPU result written; clears busy for that register
//   rd_en/add1/add2   live operand addresses this cycle
//   xfer_req/xfer_add a transfer (either direction) targets xfer_add
//   stall             combinational hazard towards the issue stage
module fp_scoreboard
    import fp_pkg::*;
#(
    parameter int NREG = fp_pkg::NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_add,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  w_add,
    input  logic                     rd_en,
    input  logic [$clog2(NREG)-1:0]  add1,
    input  logic [$clog2(NREG)-1:0]  add2,
    input  logic                     xfer_req,
    input  logic [$clog2(NREG)-1:0]  xfer_add,
    output logic                     stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[w_add] = 1'b0;
        end
        // Applied after the clear so a same-cycle issue to the register being
        // retired keeps it busy: the new op has not completed yet.
        if (issue_valid) begin
            busy_d[issue_add] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall = (rd_en && (busy_q[add1] || busy_q[add2]))
                || (xfer_req && busy_q[xfer_add]);

endmodule

// File: rtl/fp_regfile_xfer.sv
// FP (coprocessor-1) register file with the FP end of the general/FP transfer
// bus, condition-code flags and a busy scoreboard.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   we, w_add, data          FPU result write
//   rd_en, add1, add2        read addresses (rd_en gates operand stall)
//   data1, data2             combinational read data, no bypass
//   gen_to_fp, fp_to_gen     mtc1 capture / mfc1 drive requests
//   xfer_add                 FP register used by the transfer
//   fp_gen_transfer          shared tri-state transfer bus
//   issue_valid, issue_add   multi-cycle op issue (marks busy)
//   stall                    hazard on operands or transfer target
//   cc_we, cc_idx, cc_val    condition-code bit write
//   cc_out                   all condition-code bits
//   xfer_err                 registered: both transfer directions requested
module fp_regfile_xfer
    import fp_pkg::*;
#(
    parameter int NREG  = fp_pkg::NREG,
    parameter int WIDTH = fp_pkg::WIDTH,
    parameter int NCC   = fp_pkg::NCC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(NREG)-1:0]  w_add,
    input  logic [WIDTH-1:0]         data,
    input  logic                     rd_en,
    input  logic [$clog2(NREG)-1:0]  add1,
    input  logic [$clog2(NREG)-1:0]  add2,
    output logic [WIDTH-1:0]         data1,
    output logic [WIDTH-1:0]         data2,
    input  logic                     gen_to_fp,
    input  logic                     fp_to_gen,
    input  logic [$clog2(NREG)-1:0]  xfer_add,
    inout  wire  [WIDTH-1:0]         fp_gen_transfer,
    input  logic                     issue_valid,
    input  logic [$clog2(NREG)-1:0]  issue_add,
    output logic                     stall,
    input  logic                     cc_we,
    input  logic [$clog2(NCC)-1:0]   cc_idx,
    input  logic                     cc_val,
    output logic [NCC-1:0]           cc_out,
    output logic                     xfer_err
);

    xfer_dir_e        dir;
    logic [WIDTH-1:0] fp_q [NREG];
    logic [WIDTH-1:0] fp_d [NREG];
    logic [NCC-1:0]   cc_q;
    logic [NCC-1:0]   cc_d;
    logic             xfer_err_q;
    logic             xfer_err_d;

    assign dir = xfer_dir(gen_to_fp, fp_to_gen);

    // Register array next state. The capture is applied last so that a
    // transfer to the same register as the FPU write takes precedence.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            fp_d[i] = fp_q[i];
        end
        if (we) begin
            fp_d[w_add] = data;
        end
        if (dir == XFER_TO_FP) begin
            fp_d[xfer_add] = fp_gen_transfer;
        end
    end

    always_comb begin
        cc_d = cc_q;
        if (cc_we) begin
            cc_d[cc_idx] = cc_val;
        end
        xfer_err_d = (dir == XFER_CONFLICT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                fp_q[i] <= '0;
            end
            cc_q       <= '0;
            xfer_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                fp_q[i] <= fp_d[i];
            end
            cc_q       <= cc_d;
            xfer_err_q <= xfer_err_d;
        end
    end

    assign data1    = fp_q[add1];
    assign data2    = fp_q[add2];
    assign cc_out   = cc_q;
    assign xfer_err = xfer_err_q;

    // Bus is released during reset so the general side is never fought.
    assign fp_gen_transfer = (!rst && dir == XFER_TO_GEN) ? fp_q[xfer_add] : {WIDTH{1'bz}};

    fp_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_add   (issue_add),
        .we          (we),
        .w_add       (w_add),
        .rd_en       (rd_en),
        .add1        (add1),
        .add2        (add2),
        .xfer_req    (gen_to_fp || fp_to_gen),
        .xfer_add    (xfer_add),
        .stall       (stall)
    );

endmodule

// File: tb/tb_fp_regfile_xfer.sv
// Self-checking bench for fp_regfile_xfer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model held in arrays.
// Whenever the FP side must not drive the bus, the bench drives it itself
// (general-side data, or the complement of the addressed register as a probe),
// so a DUT that drives when it should not produces a bus value that differs.
module tb_fp_regfile_xfer;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  w_add;
    logic [31:0] data;
    logic        rd_en;
    logic [4:0]  add1;
    logic [4:0]  add2;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        gen_to_fp;
    logic        fp_to_gen;
    logic [4:0]  xfer_add;
    wire  [31:0] fp_gen_transfer;
    logic        issue_valid;
    logic [4:0]  issue_add;
    logic        stall;
    logic        cc_we;
    logic [2:0]  cc_idx;
    logic        cc_val;
    logic [7:0]  cc_out;
    logic        xfer_err;

    logic        drv_en;
    logic [31:0] drv_val;

    assign fp_gen_transfer = drv_en ? drv_val : 32'bz;

    fp_regfile_xfer dut (
        .clk             (clk),
        .rst             (rst),
        .we              (we),
        .w_add           (w_add),
        .data            (data),
        .rd_en           (rd_en),
        .add1            (add1),
        .add2            (add2),
        .data1           (data1),
        .data2           (data2),
        .gen_to_fp       (gen_to_fp),
        .fp_to_gen       (fp_to_gen),
        .xfer_add        (xfer_add),
        .fp_gen_transfer (fp_gen_transfer),
        .issue_valid     (issue_valid),
        .issue_add       (issue_add),
        .stall           (stall),
        .cc_we           (cc_we),
        .cc_idx          (cc_idx),
        .cc_val          (cc_val),
        .cc_out          (cc_out),
        .xfer_err        (xfer_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] fp_m [32];
    logic        busy_m [32];
    logic [7:0]  cc_m;
    logic        err_m;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        rst = 0; we = 0; w_add = 0; data = 0; rd_en = 0; add1 = 0; add2 = 0;
        gen_to_fp = 0; fp_to_gen = 0; xfer_add = 0; issue_valid = 0; issue_add = 0;
        cc_we = 0; cc_idx = 0; cc_val = 0; drv_val = 0;
    endtask

    function automatic logic [4:0] rand_addr();
        // Bias towards a small window so collisions and hazards actually occur.
        if ($urandom_range(3) != 0) return 5'($urandom_range(7));
        return 5'($urandom_range(31));
    endfunction

    // One clock cycle: inputs are already set by the caller (posedge+1 region).
    task automatic cycle(input string tag);
        logic        fp_drives;
        logic        stall_m;
        logic [31:0] bus_exp;
        fp_drives = !rst && fp_to_gen && !gen_to_fp;
        drv_en    = !fp_drives;
        if (!gen_to_fp) drv_val = ~fp_m[xfer_add];
        #2;
        bus_exp = fp_drives ? fp_m[xfer_add] : drv_val;
        check_val({tag, ":bus"}, fp_gen_transfer, bus_exp);
        if (chk_en) begin
            stall_m = (rd_en && (busy_m[add1] || busy_m[add2]))
                   || ((gen_to_fp || fp_to_gen) && busy_m[xfer_add]);
            check_val({tag, ":data1"}, data1, fp_m[add1]);
            check_val({tag, ":data2"}, data2, fp_m[add2]);
            check_val({tag, ":stall"}, {31'b0, stall}, {31'b0, stall_m});
            check_val({tag, ":cc"}, {24'b0, cc_out}, {24'b0, cc_m});
            check_val({tag, ":xerr"}, {31'b0, xfer_err}, {31'b0, err_m});
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                fp_m[i] = 0;
                busy_m[i] = 0;
            end
            cc_m  = 0;
            err_m = 0;
        end else begin
            if (we) fp_m[w_add] = data;
            if (gen_to_fp && !fp_to_gen) fp_m[xfer_add] = drv_val;
            if (we) busy_m[w_add] = 0;
            if (issue_valid) busy_m[issue_add] = 1;
            if (cc_we) cc_m[cc_idx] = cc_val;
            err_m = gen_to_fp && fp_to_gen;
        end
        $display("[%0t] %s rst=%0b we=%0b w=%0d g2f=%0b f2g=%0b x=%0d iss=%0b/%0d cc=%0b stall=%0b",
                 $time, tag, rst, we, w_add, gen_to_fp, fp_to_gen, xfer_add,
                 issue_valid, issue_add, cc_we, stall);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            fp_m[i] = 0;
            busy_m[i] = 0;
        end
        cc_m = 0;
        err_m = 0;
        drv_en = 1;
        idle();

        // Reset with an mfc1 request pending: the bus must stay released.
        chk_en = 0;
        rst = 1; fp_to_gen = 1; xfer_add = 7;
        cycle("reset");
        chk_en = 1;

        idle(); add1 = 5; add2 = 31;
        #1;
        check_val("rst_data1", data1, 32'h0);
        check_val("rst_data2", data2, 32'h0);
        check_val("rst_cc", {24'b0, cc_out}, 32'h0);
        cycle("after_rst");

        // mtc1 of 1.0f into fp[7], then mfc1 of the same register.
        idle(); gen_to_fp = 1; xfer_add = 7; drv_val = 32'h3F80_0000;
        cycle("mtc1");
        idle(); add1 = 7; fp_to_gen = 1; xfer_add = 7;
        #1;
        check_val("mtc1_rd", data1, 32'h3F80_0000);
        check_val("mfc1_bus", fp_gen_transfer, 32'h3F80_0000);
        cycle("mfc1");
        idle(); xfer_add = 7;
        cycle("release");

        // Conflict: fp[3] must keep its value, error flag pulses for one cycle.
        idle(); gen_to_fp = 1; xfer_add = 3; drv_val = 32'h1234_5678;
        cycle("pre3");
        idle(); gen_to_fp = 1; fp_to_gen = 1; xfer_add = 3; drv_val = 32'hDEAD_BEEF;
        cycle("conflict");
        idle(); add1 = 3;
        #1;
        check_val("conf_keep", data1, 32'h1234_5678);
        check_val("conf_err", {31'b0, xfer_err}, 32'h1);
        cycle("conf_after");
        check_val("conf_clear", {31'b0, xfer_err}, 32'h0);

        // Collision: transfer wins over FPU write to the same register.
        idle(); we = 1; w_add = 4; data = 32'h1; gen_to_fp = 1; xfer_add = 4; drv_val = 32'h2;
        cycle("collide");
        idle(); add1 = 4;
        #1;
        check_val("collide_rd", data1, 32'h2);
        cycle("collide_rd");

        // Scoreboard set / clear / set-wins.
        idle(); issue_valid = 1; issue_add = 9;
        cycle("issue9");
        idle(); rd_en = 1; add1 = 9;
        #1;
        check_val("sb_stall", {31'b0, stall}, 32'h1);
        cycle("stall9");
        idle(); rd_en = 1; add1 = 9; we = 1; w_add = 9; data = 32'hAAAA_0009;
        cycle("retire9");
        idle(); rd_en = 1; add1 = 9;
        #1;
        check_val("sb_clear", {31'b0, stall}, 32'h0);
        cycle("free9");
        idle(); issue_valid = 1; issue_add = 9; we = 1; w_add = 9; data = 32'h5;
        cycle("setwins9");
        idle(); rd_en = 1; add2 = 9;
        #1;
        check_val("sb_setwins", {31'b0, stall}, 32'h1);
        cycle("still9");
        idle(); we = 1; w_add = 9; data = 32'h6;
        cycle("clear9");

        // Condition codes.
        idle(); cc_we = 1; cc_idx = 2; cc_val = 1;
        cycle("cc_set");
        check_val("cc_04", {24'b0, cc_out}, 32'h04);
        idle(); cc_we = 1; cc_idx = 2; cc_val = 0;
        cycle("cc_clr");
        check_val("cc_00", {24'b0, cc_out}, 32'h00);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(63) == 0);
            we          = 1'($urandom);
            w_add       = rand_addr();
            data        = $urandom;
            rd_en       = 1'($urandom);
            add1        = rand_addr();
            add2        = rand_addr();
            gen_to_fp   = ($urandom_range(3) == 0);
            fp_to_gen   = ($urandom_range(3) == 0);
            xfer_add    = rand_addr();
            issue_valid = ($urandom_range(3) == 0);
            issue_add   = rand_addr();
            cc_we       = 1'($urandom);
            cc_idx      = 3'($urandom);
            cc_val      = 1'($urandom);
            if (gen_to_fp) drv_val = $urandom;
            cycle("rand");
        end

        idle();
        for (int a = 0; a < 32; a += 2) begin
            add1 = 5'(a); add2 = 5'(a + 1);
            cycle("sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
